// File: rtl/mio_bus_arbiter_pkg.sv
// Shared types and constants for the two-master MIO bus arbiter.
package mio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    localparam int TIMEOUT_DEF = 16;
    localparam int TW_DEF      = 5;

endpackage

// File: rtl/mio_bus_arbiter_if.sv
// Point-to-point MIO bus link between one initiator and one target.
interface mio_bus_if;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        we;
    logic        stb;
    logic        ack;
    logic        err;

    // err only flows from the arbiter back to its masters; the peripheral never raises it.
    modport master (output adr, wdat, we, stb, input rdat, ack);
    modport slave  (input adr, wdat, we, stb, output rdat, ack, err);
endinterface

// File: rtl/mio_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin winner select; the last-served pointer lives with the caller.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic grant,
    output logic valid
);
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            grant = ~last_served;
        end else begin
            grant = req1;
        end
    end
endmodule

// File: rtl/mio_bus_arbiter.sv
// Two-master arbiter/sequencer for the MIO peripheral bus with registered strobe and timeout.
module mio_bus_arbiter
    import mio_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int TW      = TW_DEF
) (
    input  logic      clk,
    input  logic      rst,
    mio_bus_if.slave  m0,
    mio_bus_if.slave  m1,
    mio_bus_if.master s,
    output logic      owner,
    output logic      busy
);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [31:0]   adr_q, adr_d, wdat_q, wdat_d;
    logic          we_q, we_d, stb_q, stb_d;
    logic [31:0]   m0_rdat_q, m0_rdat_d, m1_rdat_q, m1_rdat_d;
    logic          m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic          win, win_valid;

    rr_arbiter2 u_rr (
        .req0        (m0.stb),
        .req1        (m1.stb),
        .last_served (last_q),
        .grant       (win),
        .valid       (win_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= M_CPU;
            last_q    <= M_DBG;
            cnt_q     <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            we_q      <= 1'b0;
            stb_q     <= 1'b0;
            m0_rdat_q <= '0;
            m1_rdat_q <= '0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            we_q      <= we_d;
            stb_q     <= stb_d;
            m0_rdat_q <= m0_rdat_d;
            m1_rdat_q <= m1_rdat_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
            m0_err_q  <= m0_err_d;
            m1_err_q  <= m1_err_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = REQ;
            REQ:     if (s.ack || cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin : outputs
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        we_d      = we_q;
        stb_d     = 1'b0;
        m0_rdat_d = m0_rdat_q;
        m1_rdat_d = m1_rdat_q;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m0_err_d  = 1'b0;
        m1_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    owner_d = win;
                    adr_d   = (win == M_DBG) ? m1.adr  : m0.adr;
                    wdat_d  = (win == M_DBG) ? m1.wdat : m0.wdat;
                    we_d    = (win == M_DBG) ? m1.we   : m0.we;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                // Ack beats the timeout when both land on the same cycle.
                if (s.ack) begin
                    last_d = owner_q;
                    if (owner_q == M_DBG) begin
                        m1_rdat_d = s.rdat;
                        m1_ack_d  = 1'b1;
                    end else begin
                        m0_rdat_d = s.rdat;
                        m0_ack_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    last_d = owner_q;
                    if (owner_q == M_DBG) m1_err_d = 1'b1;
                    else                  m0_err_d = 1'b1;
                end else begin
                    stb_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign s.adr   = adr_q;
    assign s.wdat  = wdat_q;
    assign s.we    = we_q;
    assign s.stb   = stb_q;
    assign m0.rdat = m0_rdat_q;
    assign m0.ack  = m0_ack_q;
    assign m0.err  = m0_err_q;
    assign m1.rdat = m1_rdat_q;
    assign m1.ack  = m1_ack_q;
    assign m1.err  = m1_err_q;
    assign owner   = owner_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed bench for mio_bus_arbiter with a timestamp-based transaction model.
module tb_mio_bus_arbiter;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic owner, busy;

    mio_bus_if m0_bus ();
    mio_bus_if m1_bus ();
    mio_bus_if s_bus ();

    mio_bus_arbiter #(.TIMEOUT(TO), .TW(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // slave: 0 = ack echoes stb, 1 = never ack, 2 = ack only when ack_man set
    int          ack_mode = 0;
    logic        ack_man  = 1'b0;
    logic [31:0] slv_rdat = 32'h0;
    assign s_bus.ack  = (ack_mode == 0) ? s_bus.stb :
                        (ack_mode == 2) ? (s_bus.stb & ack_man) : 1'b0;
    assign s_bus.rdat = slv_rdat;
    assign s_bus.err  = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a transaction opens on the winning edge, closes on the first edge that
    // samples ack or after TO strobe cycles; the bus re-arbitrates two edges later.
    int          cyc = 0, g_edge = 0, free_edge = 0, end_edge = -10;
    bit          open_t = 0, end_ack = 0;
    logic        e_own = 1'b0, e_last = 1'b1, e_we = 1'b0;
    logic [31:0] e_adr = '0, e_wdat = '0;
    logic [31:0] e_rdat [2] = '{32'h0, 32'h0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; open_t = 0; free_edge = 0; end_edge = -10; end_ack = 0;
            e_own = 1'b0; e_last = 1'b1; e_adr = '0; e_wdat = '0; e_we = 1'b0;
            e_rdat[0] = '0; e_rdat[1] = '0;
        end else begin
            cyc++;
            if (open_t) begin
                if (s_bus.ack) begin
                    open_t = 0; end_edge = cyc; end_ack = 1; free_edge = cyc + 2;
                    e_rdat[e_own] = s_bus.rdat; e_last = e_own;
                end else if (cyc - g_edge == TO) begin
                    open_t = 0; end_edge = cyc; end_ack = 0; free_edge = cyc + 2;
                    e_last = e_own;
                end
            end else if (cyc >= free_edge && (m0_bus.stb || m1_bus.stb)) begin
                e_own  = (m0_bus.stb && m1_bus.stb) ? ~e_last : m1_bus.stb;
                e_adr  = e_own ? m1_bus.adr  : m0_bus.adr;
                e_wdat = e_own ? m1_bus.wdat : m0_bus.wdat;
                e_we   = e_own ? m1_bus.we   : m0_bus.we;
                open_t = 1; g_edge = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("s_stb",  s_bus.stb,  open_t);
            chk("s_adr",  s_bus.adr,  e_adr);
            chk("s_dat",  s_bus.wdat, e_wdat);
            chk("s_we",   s_bus.we,   e_we);
            chk("owner",  owner,      e_own);
            chk("busy",   busy,       open_t || cyc == end_edge);
            chk("m0_ack", m0_bus.ack, cyc == end_edge && end_ack && e_own == 1'b0);
            chk("m0_err", m0_bus.err, cyc == end_edge && !end_ack && e_own == 1'b0);
            chk("m1_ack", m1_bus.ack, cyc == end_edge && end_ack && e_own == 1'b1);
            chk("m1_err", m1_bus.err, cyc == end_edge && !end_ack && e_own == 1'b1);
            chk("m0_dat", m0_bus.rdat, e_rdat[0]);
            chk("m1_dat", m1_bus.rdat, e_rdat[1]);
        end
    end

    int          grants[$];
    logic [31:0] g_adr[$], g_wdat[$];
    logic        g_we[$];
    int          stb_lens[$];
    int          gap_min;
    int          ack_n[2], err_n[2], ack_cnt[2], err_cnt[2];
    logic [31:0] rd_at_ack[2];

    task automatic clr_stats();
        grants.delete(); g_adr.delete(); g_wdat.delete(); g_we.delete(); stb_lens.delete();
        gap_min = 1000;
        for (int i = 0; i < 2; i++) begin
            ack_n[i] = -1; err_n[i] = -1; ack_cnt[i] = 0; err_cnt[i] = 0; rd_at_ack[i] = '0;
        end
    endtask

    // Runs the bus until both masters are satisfied; masters drop stb on ack/err.
    task automatic serve(input int budget, input int ack_at);
        int n = 0, run = 0, low = 0;
        bit prev = 0, seen = 0, done = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            if (s_bus.stb) begin
                if (!prev) begin
                    grants.push_back(int'(owner));
                    g_adr.push_back(s_bus.adr); g_wdat.push_back(s_bus.wdat); g_we.push_back(s_bus.we);
                    if (seen && low < gap_min) gap_min = low;
                    seen = 1;
                end
                run++; low = 0;
            end else begin
                if (prev) stb_lens.push_back(run);
                run = 0; low++;
            end
            prev = s_bus.stb;
            if (m0_bus.ack) begin ack_cnt[0]++; ack_n[0] = n; rd_at_ack[0] = m0_bus.rdat; end
            if (m1_bus.ack) begin ack_cnt[1]++; ack_n[1] = n; rd_at_ack[1] = m1_bus.rdat; end
            if (m0_bus.err) begin err_cnt[0]++; err_n[0] = n; end
            if (m1_bus.err) begin err_cnt[1]++; err_n[1] = n; end
            if (m0_bus.ack || m0_bus.err) m0_bus.stb = 1'b0;
            if (m1_bus.ack || m1_bus.err) m1_bus.stb = 1'b0;
            ack_man = (n == ack_at);
            if (!m0_bus.stb && !m1_bus.stb && !busy) done = 1;
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL serve_budget: bus still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic req(input int m, input logic [31:0] adr, input logic [31:0] dat, input logic we);
        if (m == 0) begin
            m0_bus.adr = adr; m0_bus.wdat = dat; m0_bus.we = we; m0_bus.stb = 1'b1;
        end else begin
            m1_bus.adr = adr; m1_bus.wdat = dat; m1_bus.we = we; m1_bus.stb = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        m0_bus.adr = '0; m0_bus.wdat = '0; m0_bus.we = 1'b0; m0_bus.stb = 1'b0;
        m1_bus.adr = '0; m1_bus.wdat = '0; m1_bus.we = 1'b0; m1_bus.stb = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stb", s_bus.stb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        rst = 1'b0;

        // 1: single write from m0
        clr_stats();
        slv_rdat = 32'hDEAD_BEEF;
        req(0, 32'hFFFF_FF00, 32'h0000_00A5, 1'b1);
        serve(40, -1);
        chk("t1_grants", grants.size(), 1);
        if (grants.size() > 0) begin
            chk("t1_adr", g_adr[0], 32'hFFFF_FF00);
            chk("t1_dat", g_wdat[0], 32'h0000_00A5);
            chk("t1_we", g_we[0], 1);
        end
        if (stb_lens.size() > 0) chk("t1_stb_len", stb_lens[0], 1);
        chk("t1_m0_ack_cyc", ack_n[0], 2);
        chk("t1_m1_ack_cnt", ack_cnt[1], 0);

        // 2: read by m1
        clr_stats();
        slv_rdat = 32'h1234_5678;
        req(1, 32'hFFFF_FF04, 32'h0, 1'b0);
        serve(40, -1);
        chk("t2_rdat", rd_at_ack[1], 32'h1234_5678);
        chk("t2_ack_cnt", ack_cnt[1], 1);
        if (grants.size() > 0) begin
            chk("t2_owner", grants[0], 1);
            chk("t2_we", g_we[0], 0);
        end

        // 3: contention after reset, four rounds
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        clr_stats();
        for (int r = 0; r < 4; r++) begin
            slv_rdat = 32'h100 + r;
            req(0, 32'hFFFF_FF10, 32'hA0 + r, 1'b1);
            req(1, 32'hFFFF_FF14, 32'hB0 + r, 1'b0);
            serve(60, -1);
        end
        chk("t3_grant_count", grants.size(), 8);
        for (int i = 0; i < grants.size(); i++) chk("t3_grant_order", grants[i], i % 2);
        chk("t3_gap_ge2", gap_min >= 2, 1);

        // 4: timeout on m0, then m1 served normally
        clr_stats();
        ack_mode = 1;
        req(0, 32'hFFFF_FF20, 32'h5, 1'b1);
        serve(60, -1);
        chk("t4_err_cyc", err_n[0], 1 + TO);
        chk("t4_err_cnt", err_cnt[0], 1);
        chk("t4_ack_cnt", ack_cnt[0], 0);
        if (stb_lens.size() > 0) chk("t4_stb_len", stb_lens[0], TO);
        clr_stats();
        ack_mode = 0;
        slv_rdat = 32'h0BAD_F00D;
        req(1, 32'hFFFF_FF24, 32'h0, 1'b0);
        serve(40, -1);
        chk("t4_m1_ack_cnt", ack_cnt[1], 1);
        chk("t4_m1_rdat", rd_at_ack[1], 32'h0BAD_F00D);

        // 5: ack lands on the last counter value
        clr_stats();
        ack_mode = 2;
        slv_rdat = 32'h0000_5A5A;
        req(0, 32'hFFFF_FF28, 32'h0, 1'b0);
        serve(60, TO);
        chk("t5_ack_cnt", ack_cnt[0], 1);
        chk("t5_err_cnt", err_cnt[0], 0);
        chk("t5_ack_cyc", ack_n[0], 1 + TO);
        chk("t5_rdat", rd_at_ack[0], 32'h0000_5A5A);
        ack_mode = 0;

        // 6: asynchronous reset in the middle of REQ
        ack_mode = 1;
        req(0, 32'hFFFF_FF2C, 32'h77, 1'b1);
        repeat (5) @(negedge clk);
        chk("t6_in_req", s_bus.stb, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_stb", s_bus.stb, 0);
        chk("t6_adr", s_bus.adr, 0);
        chk("t6_dat", s_bus.wdat, 0);
        chk("t6_we", s_bus.we, 0);
        chk("t6_busy", busy, 0);
        chk("t6_owner", owner, 0);
        chk("t6_m0_dat", m0_bus.rdat, 0);
        m0_bus.stb = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_ack", m0_bus.ack, 0);
            chk("t6_no_err", m0_bus.err, 0);
        end
        rst = 1'b0;
        ack_mode = 0;
        clr_stats();
        req(0, 32'hFFFF_FF30, 32'h1, 1'b1);
        req(1, 32'hFFFF_FF34, 32'h2, 1'b1);
        serve(60, -1);
        chk("t6_grant_count", grants.size(), 2);
        if (grants.size() > 1) begin
            chk("t6_first_grant", grants[0], 0);
            chk("t6_second_grant", grants[1], 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
